// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential ROM reads, tracks the address of
// the instruction currently returned by the ROM, and handles stall, branch
// redirect and start/stop control. ROM read data has one cycle of latency.
module fetch_unit #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        Stop,
  input  logic        Stall,
  input  logic        Branch_en,
  input  logic [7:0]  Branch_addr,
  input  logic [15:0] Rom_data,
  output logic        Rom_en,
  output logic [7:0]  Rom_addr,
  output logic [15:0] Instr,
  output logic [7:0]  Instr_pc,
  output logic        Instr_valid,
  output logic        Busy
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t      state;
  logic [7:0]  pc;      // next address to issue
  logic [7:0]  fpc;     // address whose data is on Rom_data
  logic        fvalid;  // Rom_data holds a live instruction

  // Control state, issue pointer and fetch tracking
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      fpc    <= 8'h00;
      fvalid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            state  <= RUN;
            pc     <= pc + 8'd1;
            fpc    <= pc;
            fvalid <= 1'b1;
          end else begin
            fvalid <= 1'b0;
          end
        end
        RUN: begin
          if (Stop) begin
            state  <= IDLE;
            fvalid <= 1'b0;
          end else if (Branch_en) begin
            // The read issued this cycle (if any) is for the old stream;
            // dropping fvalid discards it and leaves one bubble.
            pc     <= Branch_addr;
            fvalid <= 1'b0;
          end else if (!Stall) begin
            pc     <= pc + 8'd1;
            fpc    <= pc;
            fvalid <= 1'b1;
          end
        end
      endcase
    end
  end

  // ROM request: address straight from the register, enable from control
  always_comb begin
    Rom_addr = pc;
    Rom_en   = 1'b0;
    if (Rst) begin
      if (state == IDLE) Rom_en = Start;
      else               Rom_en = !Stall && !Stop;
    end
  end

  // Instruction presentation to decode
  always_comb begin
    Instr_valid = fvalid;
    Instr_pc    = fpc;
    Instr       = fvalid ? Rom_data : 16'h0000;
    Busy        = (state == RUN);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected (pc, instr)
// pairs; a monitor on the falling edge compares whatever the DUT presents.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start, Stop, Stall, Branch_en;
  logic [7:0]  Branch_addr;
  logic [15:0] Rom_data = '0;
  logic        Rom_en;
  logic [7:0]  Rom_addr;
  logic [15:0] Instr;
  logic [7:0]  Instr_pc;
  logic        Instr_valid;
  logic        Busy;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  logic [23:0] sb[$];

  fetch_unit #(.RESET_PC(8'h00)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Stop(Stop), .Stall(Stall),
    .Branch_en(Branch_en), .Branch_addr(Branch_addr), .Rom_data(Rom_data),
    .Rom_en(Rom_en), .Rom_addr(Rom_addr), .Instr(Instr), .Instr_pc(Instr_pc),
    .Instr_valid(Instr_valid), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // ROM contents: distinct word per address
  function automatic logic [15:0] romv(input logic [7:0] a);
    return {a ^ 8'hA5, a};
  endfunction

  // Registered-read ROM that holds its output when not enabled
  always_ff @(posedge Clk) begin
    if (Rom_en) Rom_data <= romv(Rom_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic expect_seq(input logic [7:0] start, input int unsigned n);
    logic [7:0] a;
    a = start;
    for (int unsigned i = 0; i < n; i++) begin
      sb.push_back({a, romv(a)});
      a = a + 8'd1;
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: compare presented instruction to scoreboard head; it leaves
  // the pipe unless held by a plain stall
  always @(negedge Clk) begin
    if (Rst === 1'b1 && Instr_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid_pc", {24'h0, Instr_pc}, 32'hFFFF_FFFF);
      end else begin
        chk("mon_pc", {24'h0, Instr_pc}, {24'h0, sb[0][23:16]});
        chk("mon_instr", {16'h0, Instr}, {16'h0, sb[0][15:0]});
        if (!Stall || Branch_en || Stop) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b0; Start = 1'b0; Stop = 1'b0; Stall = 1'b0;
    Branch_en = 1'b0; Branch_addr = 8'h00;
    #2;
    chk("rst_rom_en", {31'h0, Rom_en}, 32'h0);
    chk("rst_rom_addr", {24'h0, Rom_addr}, 32'h00);
    chk("rst_instr", {16'h0, Instr}, 32'h0);
    chk("rst_instr_pc", {24'h0, Instr_pc}, 32'h0);
    chk("rst_valid", {31'h0, Instr_valid}, 32'h0);
    chk("rst_busy", {31'h0, Busy}, 32'h0);
    step(); step();
    #4 Rst = 1'b1;
    step();

    // Stop/Stall/Branch ignored in IDLE
    Branch_en = 1'b1; Branch_addr = 8'h33; Stall = 1'b1; Stop = 1'b1;
    step();
    Branch_en = 1'b0; Stall = 1'b0; Stop = 1'b0;
    chk("idle_rom_addr", {24'h0, Rom_addr}, 32'h00);
    chk("idle_busy", {31'h0, Busy}, 32'h0);
    chk("idle_valid", {31'h0, Instr_valid}, 32'h0);

    // Basic sequential fetch 00..03, then Stop
    expect_seq(8'h00, 4);
    Start = 1'b1; step(); Start = 1'b0;
    chk("seq_busy", {31'h0, Busy}, 32'h1);
    step(); step(); step();
    Stop = 1'b1; step(); Stop = 1'b0;
    chk("stop_busy", {31'h0, Busy}, 32'h0);
    chk("stop_valid", {31'h0, Instr_valid}, 32'h0);
    chk("stop_drained", sb.size(), 0);

    // Resume at held pc
    expect_seq(8'h04, 2);
    Start = 1'b1; step(); Start = 1'b0;
    chk("resume_pc", {24'h0, Instr_pc}, 32'h04);
    step();
    Stop = 1'b1; step(); Stop = 1'b0;

    // Stall during cycles 2-4
    expect_seq(8'h06, 4);
    Start = 1'b1; step(); Start = 1'b0;
    step();
    Stall = 1'b1; step(); step(); step();
    Stall = 1'b0;
    chk("stall_hold_pc", {24'h0, Instr_pc}, 32'h07);
    chk("stall_hold_valid", {31'h0, Instr_valid}, 32'h1);
    step();
    chk("stall_next_pc", {24'h0, Instr_pc}, 32'h08);
    step();
    Stop = 1'b1; step(); Stop = 1'b0;
    chk("stall_drained", sb.size(), 0);

    // Branch at cycle 3 without stall
    expect_seq(8'h0A, 3);
    expect_seq(8'h40, 2);
    Start = 1'b1; step(); Start = 1'b0;
    step(); step();
    Branch_en = 1'b1; Branch_addr = 8'h40; step(); Branch_en = 1'b0;
    chk("br_bubble", {31'h0, Instr_valid}, 32'h0);
    step();
    chk("br_target_pc", {24'h0, Instr_pc}, 32'h40);
    chk("br_target_instr", {16'h0, Instr}, {16'h0, romv(8'h40)});
    step();
    Stop = 1'b1; step(); Stop = 1'b0;

    // Branch at cycle 3 with stall
    expect_seq(8'h42, 3);
    expect_seq(8'h80, 1);
    Start = 1'b1; step(); Start = 1'b0;
    step(); step();
    Stall = 1'b1; Branch_en = 1'b1; Branch_addr = 8'h80; step();
    Stall = 1'b0; Branch_en = 1'b0;
    chk("brst_bubble", {31'h0, Instr_valid}, 32'h0);
    step();
    chk("brst_target_pc", {24'h0, Instr_pc}, 32'h80);
    Stop = 1'b1; step(); Stop = 1'b0;
    chk("brst_drained", sb.size(), 0);

    // Wrap FE, FF, 00, 01 (Start held during RUN has no effect)
    expect_seq(8'h81, 1);
    Start = 1'b1; step(); Start = 1'b0;
    Branch_en = 1'b1; Branch_addr = 8'hFE; step(); Branch_en = 1'b0;
    Stop = 1'b1; step(); Stop = 1'b0;
    chk("wrap_held_pc", {24'h0, Rom_addr}, 32'hFE);
    expect_seq(8'hFE, 4);
    Start = 1'b1; step(); step(); step();
    Start = 1'b0;
    chk("wrap_pc00", {24'h0, Instr_pc}, 32'h00);
    chk("wrap_valid", {31'h0, Instr_valid}, 32'h1);
    step();
    Stop = 1'b1; step(); Stop = 1'b0;
    chk("wrap_drained", sb.size(), 0);

    // Asynchronous reset mid-RUN
    expect_seq(8'h02, 2);
    Start = 1'b1; step(); Start = 1'b0;
    step();
    #5 Rst = 1'b0;
    #1;
    chk("arst_rom_en", {31'h0, Rom_en}, 32'h0);
    chk("arst_rom_addr", {24'h0, Rom_addr}, 32'h00);
    chk("arst_instr", {16'h0, Instr}, 32'h0);
    chk("arst_instr_pc", {24'h0, Instr_pc}, 32'h0);
    chk("arst_valid", {31'h0, Instr_valid}, 32'h0);
    chk("arst_busy", {31'h0, Busy}, 32'h0);
    step(); step();
    #3 Rst = 1'b1;
    step(); step();
    chk("post_rst_busy", {31'h0, Busy}, 32'h0);
    chk("post_rst_valid", {31'h0, Instr_valid}, 32'h0);
    expect_seq(8'h00, 1);
    Start = 1'b1; step(); Start = 1'b0;
    chk("post_rst_first_pc", {24'h0, Instr_pc}, 32'h00);
    Stop = 1'b1; step(); Stop = 1'b0;
    step();
    chk("final_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
